// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: SPI command sequencer between rx/tx shifters and a 4-entry register file.
// Latency: write strobe on the edge after the data byte; read data valid 2 edges after the opcode.
// Backpressure: tx_valid/tx_data held until tx_ready; rx has no backpressure (bytes ignored when not expected).
//
// Ports:
//   sclk, rstn                    clock, async active-low reset
//   cs_n                          chip select (sync to sclk); high ends/aborts a transaction
//   rx_data, rx_valid             received byte + 1-cycle strobe from the rx shifter
//   reg_wr_addr/data/valid        register-file write port (1-cycle strobe)
//   reg_rd_addr, reg_rd_data      register-file read port (data combinational from address)
//   tx_data, tx_valid, tx_ready   read data handed to the tx shifter
//   busy                          transaction in progress
//   err_cnt                       unknown-opcode count, saturating at 15
//
// Build option: SPI_REG_AUTOINC_EN enables burst access (address auto-increment,
// continuous writes / reads until cs_n rises). Undefined: one access per transaction.
module spi_slave_reg_ctrl #(
  parameter int         REG_SIZE = 8,
  parameter logic [5:0] CMD_WR   = 6'h04,
  parameter logic [5:0] CMD_RD   = 6'h05
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                cs_n,
  input  logic [REG_SIZE-1:0] rx_data,
  input  logic                rx_valid,
  output logic [1:0]          reg_wr_addr,
  output logic [REG_SIZE-1:0] reg_wr_data,
  output logic                reg_wr_valid,
  output logic [1:0]          reg_rd_addr,
  input  logic [REG_SIZE-1:0] reg_rd_data,
  output logic [REG_SIZE-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [3:0]          err_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    RLOAD = 3'd2,
    RSEND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;

  // Opcode byte always sits in the low 8 bits of the received word.
  logic [5:0] opc_cmd;
  logic [1:0] opc_addr;
  assign opc_cmd  = rx_data[7:2];
  assign opc_addr = rx_data[1:0];

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      reg_wr_valid <= 1'b0;
      reg_rd_addr  <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      err_cnt      <= '0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      reg_wr_valid <= 1'b0;

      if (cs_n) begin
        // Deselect wins over any byte or handshake in the same cycle.
        state    <= IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              busy <= 1'b1;
              if (opc_cmd == CMD_WR) begin
                reg_wr_addr <= opc_addr;
                state       <= WDATA;
              end else if (opc_cmd == CMD_RD) begin
                reg_rd_addr <= opc_addr;
                state       <= RLOAD;
              end else begin
                if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
                state <= DONE;
              end
            end
          end

          WDATA: begin
`ifdef SPI_REG_AUTOINC_EN
            // Advance the address the cycle after a strobe so that the strobe
            // itself is always presented with the address it was meant for.
            if (reg_wr_valid) reg_wr_addr <= reg_wr_addr + 2'd1;
            if (rx_valid) begin
              reg_wr_data  <= rx_data;
              reg_wr_valid <= 1'b1;
            end
`else
            if (rx_valid) begin
              reg_wr_data  <= rx_data;
              reg_wr_valid <= 1'b1;
              state        <= DONE;
            end
`endif
          end

          RLOAD: begin
            tx_data  <= reg_rd_data;
            tx_valid <= 1'b1;
            state    <= RSEND;
          end

          RSEND: begin
            if (tx_valid && tx_ready) begin
              tx_valid <= 1'b0;
`ifdef SPI_REG_AUTOINC_EN
              reg_rd_addr <= reg_rd_addr + 2'd1;
              state       <= RLOAD;
`else
              state       <= DONE;
`endif
            end
          end

          DONE: state <= DONE;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// tb_spi_slave_reg_ctrl: self-checking bench for spi_slave_reg_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Transactions are scored at transaction level against a simple access model.
module tb_spi_slave_reg_ctrl;

`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [1:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_valid;
  logic [1:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic [3:0] err_cnt;

  logic [7:0] reg_model [4] = '{8'h01, 8'h20, 8'h33, 8'h44};
  assign reg_rd_data = reg_model[reg_rd_addr];

  spi_slave_reg_ctrl #(.REG_SIZE(8)) dut (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_valid(reg_wr_valid),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q [$];
  logic [7:0] tx_q [$];

  // Inputs are stable from posedge+1 to the next posedge, so what is seen on
  // the falling edge is exactly what the next rising edge will act on.
  always @(negedge sclk) begin
    if (rstn) begin
      if (reg_wr_valid) wr_q.push_back({reg_wr_addr, reg_wr_data});
      if (tx_valid && tx_ready && !cs_n) tx_q.push_back(tx_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
  endtask

  // A read transaction returns regs[a], regs[a+1], ... (one entry only in single mode).
  function automatic bit tx_ok(input logic [1:0] a);
    logic [1:0] idx;
    if (tx_q.size() == 0) return 1'b0;
    if (!AUTOINC && tx_q.size() != 1) return 1'b0;
    for (int k = 0; k < tx_q.size(); k++) begin
      idx = a + 2'(k);
      if (tx_q[k] !== reg_model[idx]) return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         wr;
    logic [1:0] wa;
    logic [7:0] wd;
    bit         tx;
    logic [1:0] ra;
    bit         bad;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp_err;
    int         nb;
    int         kind;
    int         waited;
    logic [1:0] a;
    logic [1:0] wa;
    logic [7:0] op;
    logic [7:0] data [4];
    wr_t        exp_w [$];

    exp_err = 0;

    tbl[0] = '{8'h11, 8'hA5, 1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{8'h10, 8'h5A, 1'b1, 2'd0, 8'h5A, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{8'h13, 8'hFF, 1'b1, 2'd3, 8'hFF, 1'b0, 2'd0, 1'b0};
    tbl[3] = '{8'h16, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0};
    tbl[4] = '{8'h14, 8'h12, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0};
    tbl[5] = '{8'h17, 8'h11, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0};
    tbl[6] = '{8'h20, 8'h10, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1};
    tbl[7] = '{8'h0C, 8'h33, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1};

    // ---------------- reset ----------------
    #12;
    chk("rst_wr_valid", 32'(reg_wr_valid), 0);
    chk("rst_wr_addr",  32'(reg_wr_addr), 0);
    chk("rst_wr_data",  32'(reg_wr_data), 0);
    chk("rst_rd_addr",  32'(reg_rd_addr), 0);
    chk("rst_tx_data",  32'(tx_data), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_err_cnt",  32'(err_cnt), 0);
    @(posedge sclk);
    #1;
    rstn = 1'b1;
    cyc(2);

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 8; i++) begin
      wr_q.delete();
      tx_q.delete();
      tx_ready = 1'b1;
      cs_n = 1'b0;
      cyc(1);
      send_byte(tbl[i].b0);
      cyc(2);
      send_byte(tbl[i].b1);
      cyc(3);
      cs_n = 1'b1;
      cyc(2);
      if (tbl[i].bad) exp_err++;
      chk($sformatf("tbl%0d_nwr", i), wr_q.size(), tbl[i].wr ? 1 : 0);
      if (tbl[i].wr && wr_q.size() > 0) begin
        chk($sformatf("tbl%0d_wr_addr", i), 32'(wr_q[0].a), 32'(tbl[i].wa));
        chk($sformatf("tbl%0d_wr_data", i), 32'(wr_q[0].d), 32'(tbl[i].wd));
      end
      if (tbl[i].tx) chk($sformatf("tbl%0d_tx_seq", i), 32'(tx_ok(tbl[i].ra)), 1);
      else           chk($sformatf("tbl%0d_ntx", i), tx_q.size(), 0);
      chk($sformatf("tbl%0d_err", i), 32'(err_cnt), exp_err);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 0);
    end

    // ---------------- write pulse width + extra byte ----------------
    wr_q.delete();
    cs_n = 1'b0;
    cyc(1);
    send_byte(8'h11);
    cyc(1);
    send_byte(8'hA5);
    @(negedge sclk);
    chk("wr_strobe",     32'(reg_wr_valid), 1);
    chk("wr_strobe_adr", 32'(reg_wr_addr), 1);
    chk("wr_strobe_dat", 32'(reg_wr_data), 32'h A5);
    cyc(1);
    @(negedge sclk);
    chk("wr_strobe_end", 32'(reg_wr_valid), 0);
    cyc(1);
    send_byte(8'h3C);
    cyc(2);
    cs_n = 1'b1;
    cyc(2);
    chk("wr_extra_n", wr_q.size(), AUTOINC ? 2 : 1);
    if (wr_q.size() > 0)
      chk("wr_extra_last", 32'(wr_q[wr_q.size()-1]), AUTOINC ? 32'({2'd2, 8'h3C}) : 32'({2'd1, 8'hA5}));

    // ---------------- read latency + stall ----------------
    tx_q.delete();
    tx_ready = 1'b0;
    cs_n = 1'b0;
    cyc(1);
    send_byte(8'h16);
    @(negedge sclk);
    chk("rd_lat1_valid", 32'(tx_valid), 0);
    cyc(1);
    for (int s = 0; s < 5; s++) begin
      @(negedge sclk);
      chk($sformatf("rd_stall%0d_valid", s), 32'(tx_valid), 1);
      chk($sformatf("rd_stall%0d_data", s), 32'(tx_data), 32'h33);
      rx_data = 8'hC3;
      cyc(1);
    end
    tx_ready = 1'b1;
    cyc(1);
    tx_ready = 1'b0;
    @(negedge sclk);
    chk("rd_after_hs_valid", 32'(tx_valid), 0);
    cyc(1);
    @(negedge sclk);
    chk("rd_next_valid", 32'(tx_valid), AUTOINC ? 1 : 0);
    chk("rd_next_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    cyc(1);
    tx_ready = 1'b0;
    cyc(1);
    @(negedge sclk);
    chk("rd_wrap_valid", 32'(tx_valid), AUTOINC ? 1 : 0);
    cs_n = 1'b1;
    cyc(2);
    chk("rd_seq", 32'(tx_ok(2'd2)), 1);
    chk("rd_seq_n", tx_q.size(), AUTOINC ? 3 : 1);

    // ---------------- abort during write ----------------
    wr_q.delete();
    cs_n = 1'b0;
    cyc(1);
    send_byte(8'h12);
    cyc(1);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    cs_n     = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    @(negedge sclk);
    chk("abort_wr_busy",  32'(busy), 0);
    chk("abort_wr_valid", 32'(reg_wr_valid), 0);
    cyc(2);
    chk("abort_wr_nwr", wr_q.size(), 0);
    cs_n = 1'b0;
    send_byte(8'h10);
    send_byte(8'h77);
    cs_n = 1'b1;
    cyc(2);
    chk("abort_recover_n", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("abort_recover_w", 32'(wr_q[0]), 32'({2'd0, 8'h77}));

    // ---------------- abort during read ----------------
    tx_q.delete();
    tx_ready = 1'b0;
    cs_n = 1'b0;
    cyc(1);
    send_byte(8'h15);
    cyc(1);
    @(negedge sclk);
    chk("abort_rd_valid_pre", 32'(tx_valid), 1);
    chk("abort_rd_data_pre",  32'(tx_data), 32'h20);
    tx_ready = 1'b1;
    cs_n = 1'b1;
    cyc(1);
    @(negedge sclk);
    chk("abort_rd_valid", 32'(tx_valid), 0);
    chk("abort_rd_busy",  32'(busy), 0);
    cyc(1);
    chk("abort_rd_ntx", tx_q.size(), 0);

    // ---------------- randomized transactions ----------------
    for (int t = 0; t < 40; t++) begin
      wr_q.delete();
      tx_q.delete();
      exp_w.delete();
      kind = $urandom_range(0, 2);
      a    = 2'($urandom);
      case (kind)
        0: op = {6'h04, a};
        1: op = {6'h05, a};
        default: begin
          op = 8'($urandom);
          while (op[7:2] == 6'h04 || op[7:2] == 6'h05) op = 8'($urandom);
        end
      endcase
      nb = $urandom_range(1, 4);
      cs_n = 1'b0;
      tx_ready = 1'($urandom);
      cyc(1);
      send_byte(op);
      for (int k = 0; k < nb; k++) begin
        cyc($urandom_range(0, 3));
        data[k]  = 8'($urandom);
        rx_data  = data[k];
        rx_valid = 1'b1;
        tx_ready = 1'($urandom);
        cyc(1);
        rx_valid = 1'b0;
      end
      if (kind == 1) begin
        tx_ready = 1'b1;
        waited = 0;
        while (tx_q.size() == 0 && waited < 20) begin
          cyc(1);
          waited++;
        end
      end
      @(negedge sclk);
      chk($sformatf("rnd%0d_busy", t), 32'(busy), 1);
      cyc(1);
      cs_n = 1'b1;
      cyc(2);
      if (kind == 2) exp_err++;
      if (kind == 0) begin
        for (int k = 0; k < nb; k++) begin
          wa = a + 2'(k);
          if (AUTOINC || k == 0) exp_w.push_back({wa, data[k]});
        end
      end
      chk($sformatf("rnd%0d_nwr", t), wr_q.size(), exp_w.size());
      for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++)
        chk($sformatf("rnd%0d_wr%0d", t, k), 32'(wr_q[k]), 32'(exp_w[k]));
      if (kind == 1) chk($sformatf("rnd%0d_tx_seq", t), 32'(tx_ok(a)), 1);
      else           chk($sformatf("rnd%0d_ntx", t), tx_q.size(), 0);
      chk($sformatf("rnd%0d_err", t), 32'(err_cnt), exp_err > 15 ? 15 : exp_err);
    end

    // ---------------- bad opcode saturation ----------------
    wr_q.delete();
    tx_q.delete();
    tx_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      cs_n = 1'b0;
      send_byte(8'hFF);
      cyc(1);
      cs_n = 1'b1;
      cyc(1);
      exp_err++;
    end
    cyc(1);
    chk("bad_err_sat", 32'(err_cnt), exp_err > 15 ? 15 : exp_err);
    chk("bad_nwr", wr_q.size(), 0);
    chk("bad_ntx", tx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
